// File: rtl/adc_serial_reg_receiver.sv
// ============================================================================
// Module   : adc_serial_reg_receiver
// Purpose  : 3-wire ADC register-write link decoder with a 16x16 shadow
//            register file. Optional header check: ADC_RX_HEADER_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_serial_reg_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InSclk,
  input  logic        InSdata,
  input  logic        InSelect,
  output logic        FrameValid,
  output logic        FrameError,
  output logic [3:0]  FrameAddr,
  output logic [15:0] FrameData,
  output logic        Busy,
  input  logic [3:0]  RegReadAddr,
  output logic [15:0] RegReadData
);

  localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];
  localparam logic [11:0] FRAME_HEADER  = 12'h001;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT     = 3'd1,
    S_FULL      = 3'd2,
    S_DRAIN     = 3'd3,
    S_COMMIT    = 3'd4,
    S_ERROR     = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  // Synchronizers reset to 0 so Select reads low until the pin is really high:
  // a frame in flight across reset can never be mistaken for a new one.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   sel_hist_q, sel_hist_d;

  logic sclk_s, sdata_s, sel_s;
  logic sel_fall, sel_rise, sclk_valid;

  state_t        state_q, state_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [15:0]   idle_cnt_q, idle_cnt_d;
  logic [3:0]    frame_addr_q, frame_addr_d;
  logic [15:0]   frame_data_q, frame_data_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic [15:0]   regs_q [16];
  logic [15:0]   regs_d [16];
  logic          reg_we;
  logic          header_ok;
  logic          timeout;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], InSclk};
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], InSdata};
    sel_sync_d   = {sel_sync_q[SYNC_STAGES-2:0], InSelect};
    sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    sdata_s      = sdata_sync_q[SYNC_STAGES-1];
    sel_s        = sel_sync_q[SYNC_STAGES-1];
    sclk_hist_d  = sclk_s;
    sel_hist_d   = sel_s;
    sel_fall     = !sel_s && sel_hist_q;
    sel_rise     = sel_s && !sel_hist_q;
    sclk_valid   = sclk_s && !sclk_hist_q && !sel_s && !sel_hist_q;
  end

`ifdef ADC_RX_HEADER_CHECK_EN
  assign header_ok = (shift_q[31:20] == FRAME_HEADER);
`else
  logic unused_header;
  assign unused_header = ^{shift_q[31:20], FRAME_HEADER};
  assign header_ok     = 1'b1;
`endif

  assign timeout = (idle_cnt_q >= TIMEOUT_LIMIT);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    frame_addr_d = frame_addr_q;
    frame_data_d = frame_data_q;
    reg_we       = 1'b0;

    if (state_q == S_SHIFT || state_q == S_FULL) begin
      if (sclk_valid) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != 16'hFFFF) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (sel_fall) begin
          state_d    = S_SHIFT;
          idle_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (sel_rise || timeout) begin
          state_d = S_ERROR;
        end else if (sclk_valid) begin
          shift_d   = {shift_q[30:0], sdata_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (sel_rise) begin
          state_d = S_COMMIT;
          // Present the new frame on FrameAddr/FrameData alongside FrameValid.
          if (header_ok) begin
            frame_addr_d = shift_q[19:16];
            frame_data_d = shift_q[15:0];
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end else if (sclk_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sel_rise) begin
          state_d = S_ERROR;
        end
      end
      S_COMMIT: begin
        if (header_ok) begin
          reg_we  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        state_d = sel_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (sel_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_WAIT_HIGH;
      end
    endcase
  end

  // Read samples the pre-write contents, so a same-cycle collision returns old data.
  always_comb begin
    regs_d = regs_q;
    if (reg_we) begin
      regs_d[shift_q[19:16]] = shift_q[15:0];
    end
    rd_data_d = regs_q[RegReadAddr];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      sel_sync_q   <= '0;
      sclk_hist_q  <= 1'b0;
      sel_hist_q   <= 1'b0;
      state_q      <= S_WAIT_HIGH;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
      rd_data_q    <= '0;
      regs_q       <= '{default: 16'h0000};
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      sel_sync_q   <= sel_sync_d;
      sclk_hist_q  <= sclk_hist_d;
      sel_hist_q   <= sel_hist_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
      rd_data_q    <= rd_data_d;
      regs_q       <= regs_d;
    end
  end

  assign FrameValid  = (state_q == S_COMMIT) && header_ok;
  assign FrameError  = (state_q == S_ERROR);
  assign Busy        = (state_q == S_SHIFT) || (state_q == S_FULL);
  assign FrameAddr   = frame_addr_q;
  assign FrameData   = frame_data_q;
  assign RegReadData = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_reg_receiver.sv
// ============================================================================
// Module   : tb_adc_serial_reg_receiver
// Purpose  : Self-checking bench: frame table plus scoreboard of frame events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc_serial_reg_receiver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InSclk;
  logic        InSdata;
  logic        InSelect;
  logic        FrameValid;
  logic        FrameError;
  logic [3:0]  FrameAddr;
  logic [15:0] FrameData;
  logic        Busy;
  logic [3:0]  RegReadAddr;
  logic [15:0] RegReadData;

  adc_serial_reg_receiver #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InSclk     (InSclk),
    .InSdata    (InSdata),
    .InSelect   (InSelect),
    .FrameValid (FrameValid),
    .FrameError (FrameError),
    .FrameAddr  (FrameAddr),
    .FrameData  (FrameData),
    .Busy       (Busy),
    .RegReadAddr(RegReadAddr),
    .RegReadData(RegReadData)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        is_err;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [11:0] hdr;
    logic [3:0]  addr;
    logic [15:0] data;
    int          nbits;
    bit          exp_ok;
  } vec_t;

  exp_t        exp_q[$];
  logic [15:0] model [16];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic clock_bit(input logic b);
    InSdata = b;
    cyc(4);
    InSclk = 1'b1;
    cyc(4);
    InSclk = 1'b0;
  endtask

  // Sclk = Clock/8; returns right after Select is raised.
  task automatic send_frame(input logic [11:0] hdr, input logic [3:0] a,
                            input logic [15:0] d, input int nbits);
    logic [31:0] frame;
    frame    = {hdr, a, d};
    InSelect = 1'b0;
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      clock_bit((i < 32) ? frame[31-i] : 1'b0);
    end
    cyc(4);
    InSelect = 1'b1;
  endtask

  task automatic push_exp(input logic is_err, input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    e.is_err = is_err;
    e.addr   = a;
    e.data   = d;
    exp_q.push_back(e);
    if (!is_err) model[a] = d;
  endtask

  task automatic readback_all();
    for (int a = 0; a < 16; a++) begin
      RegReadAddr = a[3:0];
      @(posedge Clock);
      @(negedge Clock);
      check($sformatf("reg_read[%0d]", a), {16'h0, RegReadData}, {16'h0, model[a]});
    end
  endtask

  // Scoreboard: every FrameValid/FrameError cycle must match the next expected event.
  always @(negedge Clock) begin
    if (!Reset && (FrameValid || FrameError)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got valid=%0b error=%0b required none",
                 FrameValid, FrameError);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {30'h0, FrameValid, FrameError}, {30'h0, !e.is_err, e.is_err});
        if (!e.is_err) begin
          check("frame_addr", {28'h0, FrameAddr}, {28'h0, e.addr});
          check("frame_data", {16'h0, FrameData}, {16'h0, e.data});
        end
      end
    end
  end

  initial begin
    vec_t        vecs [8];
    logic [15:0] old;
    int          k;

    vecs[0] = '{hdr: 12'h001, addr: 4'hA, data: 16'hFF7F, nbits: 32, exp_ok: 1'b1};
    vecs[1] = '{hdr: 12'h001, addr: 4'h3, data: 16'h1234, nbits: 32, exp_ok: 1'b1};
    vecs[2] = '{hdr: 12'h001, addr: 4'h5, data: 16'hDEAD, nbits: 31, exp_ok: 1'b0};
    vecs[3] = '{hdr: 12'h001, addr: 4'h5, data: 16'hBEEF, nbits: 33, exp_ok: 1'b0};
`ifdef ADC_RX_HEADER_CHECK_EN
    vecs[4] = '{hdr: 12'h002, addr: 4'h7, data: 16'h5555, nbits: 32, exp_ok: 1'b0};
`else
    vecs[4] = '{hdr: 12'h002, addr: 4'h7, data: 16'h5555, nbits: 32, exp_ok: 1'b1};
`endif
    vecs[5] = '{hdr: 12'h001, addr: 4'hF, data: 16'hFFFF, nbits: 32, exp_ok: 1'b1};
    vecs[6] = '{hdr: 12'h001, addr: 4'h0, data: 16'h8000, nbits: 32, exp_ok: 1'b1};
    vecs[7] = '{hdr: 12'h001, addr: 4'hA, data: 16'h0001, nbits: 32, exp_ok: 1'b1};

    for (int a = 0; a < 16; a++) model[a] = 16'h0000;

    Reset       = 1'b1;
    InSclk      = 1'b0;
    InSdata     = 1'b0;
    InSelect    = 1'b1;
    RegReadAddr = 4'h0;
    cyc(5);
    check("reset_valid", {31'h0, FrameValid}, 32'h0);
    check("reset_error", {31'h0, FrameError}, 32'h0);
    check("reset_busy",  {31'h0, Busy},       32'h0);
    check("reset_addr",  {28'h0, FrameAddr},  32'h0);
    check("reset_data",  {16'h0, FrameData},  32'h0);
    check("reset_rdata", {16'h0, RegReadData}, 32'h0);
    Reset = 1'b0;
    cyc(6);

    for (int i = 0; i < 8; i++) begin
      push_exp(!vecs[i].exp_ok, vecs[i].addr, vecs[i].data);
      send_frame(vecs[i].hdr, vecs[i].addr, vecs[i].data, vecs[i].nbits);
      cyc(12);
      check($sformatf("vec%0d_event_seen", i), exp_q.size(), 32'h0);
    end
    readback_all();

    // Commit-to-read timing: old data one cycle after the read address, new data after two.
    old = model[4'hA];
    push_exp(1'b0, 4'hA, 16'h5A5A);
    send_frame(12'h001, 4'hA, 16'h5A5A, 32);
    k = 0;
    while (!FrameValid && k < 100) begin
      @(negedge Clock);
      k++;
    end
    check("commit_wait_bound", {31'h0, FrameValid}, 32'h1);
    RegReadAddr = 4'hA;
    @(posedge Clock);
    #1 check("read_during_write_old", {16'h0, RegReadData}, {16'h0, old});
    @(posedge Clock);
    #1 check("read_after_commit_new", {16'h0, RegReadData}, 32'h5A5A);
    cyc(10);

    // Timeout: 10 bits, then Select parked low with no Sclk.
    push_exp(1'b1, 4'h0, 16'h0);
    InSelect = 1'b0;
    cyc(4);
    for (int i = 0; i < 10; i++) clock_bit(i[0]);
    cyc(2);
    check("busy_in_shift", {31'h0, Busy}, 32'h1);
    cyc(1200);
    check("timeout_event_seen", exp_q.size(), 32'h0);
    check("busy_after_timeout", {31'h0, Busy}, 32'h0);
    InSelect = 1'b1;
    cyc(10);
    push_exp(1'b0, 4'h3, 16'h0BAD);
    send_frame(12'h001, 4'h3, 16'h0BAD, 32);
    cyc(12);
    check("post_timeout_frame_seen", exp_q.size(), 32'h0);
    readback_all();

    // Reset at bit 16 with Select still low: the rest of that frame must be ignored.
    InSelect = 1'b0;
    cyc(4);
    for (int i = 0; i < 16; i++) clock_bit(1'b1);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    for (int a = 0; a < 16; a++) model[a] = 16'h0000;
    for (int i = 0; i < 16; i++) clock_bit(1'b0);
    check("busy_after_reset", {31'h0, Busy}, 32'h0);
    cyc(4);
    InSelect = 1'b1;
    cyc(12);
    push_exp(1'b0, 4'h6, 16'hC3C3);
    send_frame(12'h001, 4'h6, 16'hC3C3, 32);
    cyc(12);
    readback_all();

    check("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_serial_reg_receiver.md
# adc_serial_reg_receiver

Receive-side decoder for the 3-wire ADC register write link (Sclk / Sdata / Select). It oversamples the three pins in the Clock domain and reassembles 32-bit frames. Each complete frame is committed to a 16 x 16 shadow register file, and per-frame status is reported. The block sits on the ADC board-side pins as a write monitor and serves as the bench responder for the ADC register write master, so every init, DES-enable and DES-disable write is checked bit-exact.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the pin synchronizers (legal 2..4).
- TIMEOUT_CYCLES, 1024, Clock cycles Select may stay low with no Sclk rising edge before the frame is abandoned (legal 16..65535).
- Clock  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  synchronous, active-high.
- InSclk  input  1  serial clock, asynchronous; data is sampled on its rising edge.
- InSdata  input  1  serial data, MSB first, asynchronous.
- InSelect  input  1  frame select, active low, asynchronous.
- FrameValid  output  1  one-cycle pulse when a good frame is committed.
- FrameError  output  1  one-cycle pulse when a frame is rejected.
- FrameAddr  output  4  address of the last committed frame.
- FrameData  output  16  data of the last committed frame.
- Busy  output  1  high in states SHIFT and FULL.
- RegReadAddr  input  4  shadow register read address.
- RegReadData  output  16  registered read data, 1-cycle latency.

## Operation
- Synchronizers: SYNC_STAGES flops per pin, then one history flop. A rising edge is detected as sync=1 and history=0; a falling edge is the reverse.
- Frame layout: bits 31:20 are the header (12'h001), bits 19:16 the address, bits 15:0 the data. The 32-bit shift register shifts left and takes Sdata into bit 0.
- A valid Sclk edge is a synced Sclk rise with synced Select low in both the current and history samples. Sclk edges in the same cycle as a Select edge are ignored.
- States:
  - IDLE: Busy=0, BitCnt=0. Goes to SHIFT on a synced Select falling edge.
  - SHIFT: each valid Sclk edge shifts in one bit and increments the 6-bit BitCnt. Goes to FULL when BitCnt reaches 32.
  - FULL: waits for Select to rise.
  - Select rising in FULL goes to COMMIT.
  - Select rising in SHIFT (BitCnt<32) goes to ERROR.
  - A valid Sclk edge in FULL (33rd bit) goes to DRAIN, with the error flag latched.
  - DRAIN: waits for Select to rise, then goes to ERROR.
  - Timeout: a 16-bit idle counter clears on each valid Sclk edge and on entry to SHIFT. When it reaches TIMEOUT_CYCLES in SHIFT or FULL, the FSM goes to ERROR, then to WAIT_HIGH.
  - COMMIT (1 cycle): writes Reg[addr] <= data, updates FrameAddr/FrameData, pulses FrameValid, then returns to IDLE.
  - ERROR (1 cycle): pulses FrameError and writes nothing. Goes to IDLE if synced Select is high, otherwise to WAIT_HIGH.
  - WAIT_HIGH: goes to IDLE when synced Select is 1.
- Reset mid-frame: the frame is dropped and the FSM goes to WAIT_HIGH. A frame already in progress is never accepted after reset; only a fresh Select falling edge after Select has been high starts a frame.
- Writes to the same address overwrite. A read and a write to the same address in the same cycle returns the old data.

## Timing
- Reset values:
  - FrameValid, FrameError, Busy: 0.
  - FrameAddr, FrameData, RegReadData: 0.
  - All 16 registers: 16'h0000.
  - State: WAIT_HIGH.
- Pin-to-detect latency is SYNC_STAGES+1 cycles.
- FrameValid rises exactly 1 cycle after the Select rising edge is detected.
- The shadow register is readable with the new value 2 cycles after FrameValid: 1 cycle for the write, 1 cycle of read latency.
- Input requirements:
  - Sclk high and low each at least 2 Clock periods.
  - Select setup before the first Sclk rise of at least 2 Clock periods.
  - Select hold after the last Sclk rise of at least 2 Clock periods.
  - Violations are undefined apart from the timeout recovery.
- Back-to-back frames need at least 2 Clock periods of Select high between them.

## Configuration
- ADC_RX_HEADER_CHECK_EN:
  - Defined: in COMMIT, a header not equal to 12'h001 goes to ERROR instead. There is no register write and no FrameValid, and FrameError pulses.
  - Undefined: header bits are ignored and any 32-bit frame commits.

## Test plan
- Good frame: header 001, addr 4'hA, data 16'hFF7F, Sclk = Clock/8 → FrameValid one pulse. FrameAddr=A, FrameData=FF7F. Reading addr A returns FF7F 2 cycles later, and no FrameError.
- Short frame: Select rises after 31 bits → FrameError one pulse. All registers stay unchanged and the FSM returns to IDLE.
- Long frame: 33 Sclk rises → FrameError pulses only after Select rises, with no write.
- Timeout: Select held low with 10 bits sent, then idle for 1024 cycles → FrameError pulses. The FSM sits in WAIT_HIGH until Select is high, and the next good frame to addr 3 commits.
- Header check:
  - Macro defined, header 12'h002 → FrameError, no write.
  - Macro undefined, same frame → FrameValid, with the register written.
- Reset at bit 16, Select still low, 16 more bits then Select high → no FrameValid and no FrameError. The next full frame commits.
